// File: rtl/xm23_pkg.sv
// Shared XM23 definitions: ALU operation codes, PSW bit positions and the
// per-operation flag-update selector used by the ALU.
package xm23_pkg;

  localparam int unsigned WORD_W = 16;

  // ALU operation codes (alu_op[4:0]); alu_op[5] selects byte mode.
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_ADDC = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_SUBC = 5'd3;
  localparam logic [4:0] OP_DADD = 5'd4;
  localparam logic [4:0] OP_CMP  = 5'd5;
  localparam logic [4:0] OP_XOR  = 5'd6;
  localparam logic [4:0] OP_AND  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_BIT  = 5'd9;
  localparam logic [4:0] OP_BIC  = 5'd10;
  localparam logic [4:0] OP_BIS  = 5'd11;
  localparam logic [4:0] OP_MOV  = 5'd12;
  localparam logic [4:0] OP_SRA  = 5'd13;
  localparam logic [4:0] OP_RRC  = 5'd14;
  localparam logic [4:0] OP_SWPB = 5'd15;
  localparam logic [4:0] OP_SXT  = 5'd16;

  // PSW bit positions.
  localparam int unsigned PSW_C   = 0;
  localparam int unsigned PSW_Z   = 1;
  localparam int unsigned PSW_N   = 2;
  localparam int unsigned PSW_SLP = 3;
  localparam int unsigned PSW_V   = 4;

  // Which PSW flags an operation is allowed to overwrite.
  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } flag_sel_t;

endpackage

// File: rtl/xm23_alu_if.sv
// Operand/control/result bundle between the XM23 control path and the ALU.
// The control side is the master; the ALU is the slave.
interface xm23_alu_if;
  logic [15:0] s_bus;
  logic [15:0] d_bus;
  logic [5:0]  alu_op;
  logic [15:0] psw_in;
  logic        alu_E;
  logic        psw_update;
  logic [15:0] alu_out;
  logic [15:0] alu_psw_out;

  modport master (
    output s_bus, d_bus, alu_op, psw_in, alu_E, psw_update,
    input  alu_out, alu_psw_out
  );

  modport slave (
    input  s_bus, d_bus, alu_op, psw_in, alu_E, psw_update,
    output alu_out, alu_psw_out
  );
endinterface

// File: rtl/xm23_bcd_digit.sv
// Single BCD digit adder: a + b + cin, corrected by +6 when the binary sum
// exceeds 9. Four of these ripple together for DADD.
module xm23_bcd_digit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] raw;
  logic [4:0] adj;

  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    adj  = raw + 5'd6;
    cout = (raw > 5'd9);
    sum  = cout ? adj[3:0] : raw[3:0];
  end
endmodule

// File: rtl/xm23_alu.sv
// XM23 arithmetic/logic unit: combines D and S per alu_op and registers the
// result and the next PSW (C/Z/N/V recomputed, all other bits passed through).
module xm23_alu
  import xm23_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  xm23_alu_if.slave  bus
);

  logic [15:0] d, s;
  logic [4:0]  op;
  logic        byte_mode;
  logic        c_in, v_in;

  assign d         = bus.d_bus;
  assign s         = bus.s_bus;
  assign op        = bus.alu_op[4:0];
  assign byte_mode = bus.alu_op[5];
  assign c_in      = bus.psw_in[PSW_C];
  assign v_in      = bus.psw_in[PSW_V];

  // ---------------------------------------------------------------------------
  // Shared adder: SUB-type ops add the one's complement of S.
  logic [15:0] op_b;
  logic        add_cin;
  logic [16:0] sum_w;
  logic        carry7;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    op_b    = s;
    add_cin = 1'b0;
    case (op)
      OP_ADDC:        add_cin = c_in;
      OP_SUB, OP_CMP: begin op_b = ~s; add_cin = 1'b1; end
      OP_SUBC:        begin op_b = ~s; add_cin = c_in; end
      default:        ;
    endcase
  end

  assign sum_w  = {1'b0, d} + {1'b0, op_b} + {16'd0, add_cin};
  // Carry out of bit 7 is the carry into bit 8 of the word sum.
  assign carry7 = sum_w[8] ^ d[8] ^ op_b[8];

  // ---------------------------------------------------------------------------
  // BCD ripple chain for DADD; byte mode simply takes the carry after digit 1.
  logic [15:0] bcd_sum;
  logic [4:0]  bcd_c;

  assign bcd_c[0] = c_in;

  for (genvar i = 0; i < 4; i++) begin : g_bcd
    xm23_bcd_digit u_digit (
      .a    (d[4*i +: 4]),
      .b    (s[4*i +: 4]),
      .cin  (bcd_c[i]),
      .sum  (bcd_sum[4*i +: 4]),
      .cout (bcd_c[i+1])
    );
  end

  // ---------------------------------------------------------------------------
  // Operation decode: full-width result plus the value the Z/N flags look at.
  logic [15:0] res, flag_src;
  logic        word_op;
  logic        new_c;
  flag_sel_t   upd;

  always_comb begin
    res      = d;
    flag_src = d;
    word_op  = !byte_mode;
    new_c    = c_in;
    upd      = '0;
    case (op)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: begin
        res      = (op == OP_CMP) ? d : sum_w[15:0];
        flag_src = sum_w[15:0];
        new_c    = byte_mode ? carry7 : sum_w[16];
        upd      = '{c: 1'b1, z: 1'b1, n: 1'b1, v: 1'b1};
      end
      OP_DADD: begin
        res      = bcd_sum;
        flag_src = bcd_sum;
        new_c    = byte_mode ? bcd_c[2] : bcd_c[4];
        upd      = '{c: 1'b1, z: 1'b1, n: 1'b1, v: 1'b0};
      end
      OP_XOR, OP_AND, OP_OR, OP_BIT, OP_BIC, OP_BIS: begin
        case (op)
          OP_XOR:  res = d ^ s;
          OP_AND:  res = d & s;
          OP_OR:   res = d | s;
          OP_BIC:  res = d & ~s;
          OP_BIS:  res = d | s;
          default: res = d;
        endcase
        flag_src = (op == OP_BIT) ? (d & s) : res;
        upd      = '{c: 1'b0, z: 1'b1, n: 1'b1, v: 1'b0};
      end
      OP_MOV: begin
        res      = s;
        flag_src = s;
      end
      OP_SRA, OP_RRC: begin
        // Bit shifted in lands at bit 7 in byte mode, bit 15 in word mode.
        res = {(op == OP_SRA) ? d[15] : c_in, d[15:1]};
        if (byte_mode) res[7] = (op == OP_SRA) ? d[7] : c_in;
        flag_src = res;
        new_c    = d[0];
        upd      = '{c: 1'b1, z: 1'b1, n: 1'b1, v: 1'b0};
      end
      OP_SWPB, OP_SXT: begin
        res      = (op == OP_SWPB) ? {d[7:0], d[15:8]} : {{8{d[7]}}, d[7:0]};
        flag_src = res;
        word_op  = 1'b1;
        upd      = '{c: 1'b0, z: 1'b1, n: 1'b1, v: 1'b0};
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Byte-mode merge, flag derivation and next-PSW assembly.
  logic [15:0] out_val, fv, psw_next;
  logic        z_flag, n_flag, new_v;
  logic        d_msb, b_msb, r_msb;

  always_comb begin
    out_val = word_op ? res : {d[15:8], res[7:0]};
    fv      = flag_src;
    z_flag  = word_op ? (fv == 16'd0) : (fv[7:0] == 8'd0);
    n_flag  = word_op ? fv[15] : fv[7];

    d_msb   = byte_mode ? d[7]     : d[15];
    b_msb   = byte_mode ? op_b[7]  : op_b[15];
    r_msb   = byte_mode ? sum_w[7] : sum_w[15];
    new_v   = (d_msb == b_msb) && (r_msb != d_msb);

    psw_next = bus.psw_in;
    if (bus.psw_update) begin
      if (upd.c) psw_next[PSW_C] = new_c;
      if (upd.z) psw_next[PSW_Z] = z_flag;
      if (upd.n) psw_next[PSW_N] = n_flag;
      if (upd.v) psw_next[PSW_V] = new_v;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers; reset wins over alu_E.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (Reset) begin
      bus.alu_out     <= '0;
      bus.alu_psw_out <= '0;
    end else begin
      bus.alu_psw_out <= bus.alu_E ? psw_next : bus.psw_in;
      if (bus.alu_E) bus.alu_out <= out_val;
    end
  end

endmodule

// File: tb/tb_xm23_alu.sv
// Directed self-checking bench for xm23_alu: hand-computed vectors per
// feature, each result sampled 1 time unit after the active clock edge.
module tb_xm23_alu;

  logic Clock;
  logic Reset;
  int   tests_run;
  int   tests_failed;

  xm23_alu_if bus ();

  xm23_alu dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [5:0]  op;
    logic [15:0] d;
    logic [15:0] s;
    logic [15:0] psw;
    logic [15:0] exp_out;
    logic [15:0] exp_psw;
  } vec_t;

  task automatic drive(input logic e, input logic upd, input logic [5:0] op,
                       input logic [15:0] d, input logic [15:0] s, input logic [15:0] psw);
    bus.alu_E      = e;
    bus.psw_update = upd;
    bus.alu_op     = op;
    bus.d_bus      = d;
    bus.s_bus      = s;
    bus.psw_in     = psw;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    drive(1'b1, 1'b1, 6'h00, 16'h1234, 16'h4321, 16'hFFFF);
    Reset = 1'b0;
    tests_run++;
    if (bus.alu_out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_out: got %h expected 0000", bus.alu_out);
    end
    tests_run++;
    if (bus.alu_psw_out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_psw: got %h expected 0000", bus.alu_psw_out);
    end
  endtask

  task automatic test_arith();
    vec_t tbl [7];
    tbl[0] = '{6'h00, 16'h7FFF, 16'h0001, 16'h0000, 16'h8000, 16'h0014};
    tbl[1] = '{6'h00, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h0003};
    tbl[2] = '{6'h01, 16'h0001, 16'h0001, 16'h0001, 16'h0003, 16'h0000};
    tbl[3] = '{6'h22, 16'h12FF, 16'h00FF, 16'h0000, 16'h1200, 16'h0003};
    tbl[4] = '{6'h02, 16'h8000, 16'h0001, 16'h0000, 16'h7FFF, 16'h0011};
    tbl[5] = '{6'h03, 16'h0005, 16'h0003, 16'h0000, 16'h0001, 16'h0001};
    tbl[6] = '{6'h20, 16'h007F, 16'h0001, 16'h0000, 16'h0080, 16'h0014};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, tbl[i].op, tbl[i].d, tbl[i].s, tbl[i].psw);
      tests_run++;
      if (bus.alu_out !== tbl[i].exp_out) begin
        tests_failed++;
        $display("FAIL arith[%0d]_out: got %h expected %h", i, bus.alu_out, tbl[i].exp_out);
      end
      tests_run++;
      if (bus.alu_psw_out !== tbl[i].exp_psw) begin
        tests_failed++;
        $display("FAIL arith[%0d]_psw: got %h expected %h", i, bus.alu_psw_out, tbl[i].exp_psw);
      end
    end
  endtask

  task automatic test_dadd();
    // Only the carry flag is pinned down for DADD; Z/N are not compared.
    drive(1'b1, 1'b1, 6'h04, 16'h0999, 16'h0001, 16'h0001);
    tests_run++;
    if (bus.alu_out !== 16'h1001) begin
      tests_failed++;
      $display("FAIL dadd_word_out: got %h expected 1001", bus.alu_out);
    end
    tests_run++;
    if (bus.alu_psw_out[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL dadd_word_c: got %b expected 0", bus.alu_psw_out[0]);
    end
    drive(1'b1, 1'b1, 6'h24, 16'h1299, 16'h0001, 16'h0000);
    tests_run++;
    if (bus.alu_out !== 16'h1200) begin
      tests_failed++;
      $display("FAIL dadd_byte_out: got %h expected 1200", bus.alu_out);
    end
    tests_run++;
    if (bus.alu_psw_out[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL dadd_byte_c: got %b expected 1", bus.alu_psw_out[0]);
    end
  endtask

  task automatic test_logic();
    vec_t tbl [6];
    tbl[0] = '{6'h06, 16'hF0F0, 16'hFF00, 16'h0011, 16'h0FF0, 16'h0011};
    tbl[1] = '{6'h0A, 16'hFFFF, 16'h00FF, 16'h0000, 16'hFF00, 16'h0004};
    tbl[2] = '{6'h09, 16'h00F0, 16'h000F, 16'h0000, 16'h00F0, 16'h0002};
    tbl[3] = '{6'h27, 16'hAB0F, 16'hFFF0, 16'h0000, 16'hAB00, 16'h0002};
    tbl[4] = '{6'h08, 16'h1200, 16'h0034, 16'h0004, 16'h1234, 16'h0000};
    tbl[5] = '{6'h2B, 16'h0000, 16'h0080, 16'h0000, 16'h0080, 16'h0004};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, tbl[i].op, tbl[i].d, tbl[i].s, tbl[i].psw);
      tests_run++;
      if (bus.alu_out !== tbl[i].exp_out) begin
        tests_failed++;
        $display("FAIL logic[%0d]_out: got %h expected %h", i, bus.alu_out, tbl[i].exp_out);
      end
      tests_run++;
      if (bus.alu_psw_out !== tbl[i].exp_psw) begin
        tests_failed++;
        $display("FAIL logic[%0d]_psw: got %h expected %h", i, bus.alu_psw_out, tbl[i].exp_psw);
      end
    end
  endtask

  task automatic test_shift_swap();
    vec_t tbl [6];
    tbl[0] = '{6'h0E, 16'h0001, 16'h0000, 16'h0001, 16'h8000, 16'h0005};
    tbl[1] = '{6'h2D, 16'h1281, 16'h0000, 16'h0000, 16'h12C0, 16'h0005};
    tbl[2] = '{6'h0D, 16'h8002, 16'h0000, 16'h0001, 16'hC001, 16'h0004};
    tbl[3] = '{6'h2F, 16'h1280, 16'h0000, 16'h0000, 16'h8012, 16'h0004};
    tbl[4] = '{6'h10, 16'h1280, 16'h0000, 16'h0000, 16'hFF80, 16'h0004};
    tbl[5] = '{6'h2E, 16'hFF02, 16'h0000, 16'h0001, 16'hFF81, 16'h0004};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, tbl[i].op, tbl[i].d, tbl[i].s, tbl[i].psw);
      tests_run++;
      if (bus.alu_out !== tbl[i].exp_out) begin
        tests_failed++;
        $display("FAIL shift[%0d]_out: got %h expected %h", i, bus.alu_out, tbl[i].exp_out);
      end
      tests_run++;
      if (bus.alu_psw_out !== tbl[i].exp_psw) begin
        tests_failed++;
        $display("FAIL shift[%0d]_psw: got %h expected %h", i, bus.alu_psw_out, tbl[i].exp_psw);
      end
    end
  endtask

  task automatic test_passthru();
    vec_t tbl [5];
    tbl[0] = '{6'h0C, 16'h1111, 16'hABCD, 16'h001F, 16'hABCD, 16'h001F};
    tbl[1] = '{6'h14, 16'h5A5A, 16'h0F0F, 16'h0015, 16'h5A5A, 16'h0015};
    tbl[2] = '{6'h00, 16'h0000, 16'h0000, 16'hFF08, 16'h0000, 16'hFF0A};
    tbl[3] = '{6'h05, 16'h0005, 16'h0005, 16'h0000, 16'h0005, 16'h0003};
    tbl[4] = '{6'h05, 16'h0005, 16'h0005, 16'h0008, 16'h0005, 16'h0008};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, (i != 4), tbl[i].op, tbl[i].d, tbl[i].s, tbl[i].psw);
      tests_run++;
      if (bus.alu_out !== tbl[i].exp_out) begin
        tests_failed++;
        $display("FAIL passthru[%0d]_out: got %h expected %h", i, bus.alu_out, tbl[i].exp_out);
      end
      tests_run++;
      if (bus.alu_psw_out !== tbl[i].exp_psw) begin
        tests_failed++;
        $display("FAIL passthru[%0d]_psw: got %h expected %h", i, bus.alu_psw_out, tbl[i].exp_psw);
      end
    end
  endtask

  task automatic test_enable_low();
    drive(1'b1, 1'b1, 6'h00, 16'h0003, 16'h0004, 16'h0000);
    drive(1'b0, 1'b1, 6'h00, 16'h0001, 16'h0001, 16'h00A5);
    tests_run++;
    if (bus.alu_out !== 16'h0007) begin
      tests_failed++;
      $display("FAIL enable_low_hold: got %h expected 0007", bus.alu_out);
    end
    tests_run++;
    if (bus.alu_psw_out !== 16'h00A5) begin
      tests_failed++;
      $display("FAIL enable_low_psw: got %h expected 00A5", bus.alu_psw_out);
    end
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    Reset          = 1'b0;
    bus.alu_E      = 1'b0;
    bus.psw_update = 1'b0;
    bus.alu_op     = 6'h00;
    bus.d_bus      = 16'h0000;
    bus.s_bus      = 16'h0000;
    bus.psw_in     = 16'h0000;
    #2;
    test_reset();
    test_arith();
    test_dadd();
    test_logic();
    test_shift_swap();
    test_passthru();
    test_enable_low();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
